image_uart_tx: RTL
==================

Name: image_uart_tx

Overview:
- Downstream stage of the down-sampling processor.
- Once the processor asserts END_FLAG, this block reads the output image memory sequentially from address 0 and serialises each pixel byte onto a UART TX line (8N1, LSB first) for host readback.
- It shares the output image memory read port with the host side; the processor only writes that memory.

Parameters:
- CLKS_PER_BIT, 434: clock cycles per UART bit (50 MHz / 115200 baud). Must be >= 2.
- NUM_PIXELS, 65536: number of output pixels to send, at addresses 0 .. NUM_PIXELS-1. Must be >= 1 and <= 2^ADDR_W.
- ADDR_W, 19: output memory address width.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-low reset.
- START_TX  in  1  start request; connected to the processor END_FLAG (level).
- MO_rd_data  in  8  output memory read data; valid one cycle after RD_MO.
- MO_rd_add  out  ADDR_W  output memory read address.
- RD_MO  out  1  output memory read strobe.
- TX  out  1  UART serial line; idles high.
- TX_BUSY  out  1  high while a transfer is in progress.
- TX_DONE  out  1  high once all pixels have been sent.

Behaviour:
- Reset (rst=0 at a clock edge):
  - Outputs: TX=1, RD_MO=0, MO_rd_add=0, TX_BUSY=0, TX_DONE=0.
  - State goes to IDLE; bit counter, baud counter and shift register are cleared.
  - Reset applies from any state. A partial frame is abandoned and TX is high on the cycle after reset.
- Start detection: a rising edge of START_TX, registered and sampled in IDLE only. A high level present on exit from reset does not count as an edge.
- States:
  - IDLE: TX=1. On a START_TX rising edge: MO_rd_add=0, go to READ.
  - READ (1 cycle): RD_MO=1 with the current MO_rd_add; TX_BUSY=1. Go to WAIT.
  - WAIT (1 cycle): RD_MO=0. Latch MO_rd_data into the shift register at the end of the cycle. Go to START.
  - START (CLKS_PER_BIT cycles): TX=0.
  - DATA (8 x CLKS_PER_BIT cycles): TX = shift register bit 0; shift right after each bit period.
  - STOP (CLKS_PER_BIT cycles): TX=1. At the end of the period:
    - if MO_rd_add == NUM_PIXELS-1, go to DONE;
    - otherwise increment MO_rd_add and go to READ.
  - DONE: TX=1, TX_BUSY=0, TX_DONE=1. Hold until START_TX=0, then go to IDLE (TX_DONE falls that same transition).
- Timing:
  - Per-byte period is 10*CLKS_PER_BIT + 2 cycles, including the READ and WAIT overhead.
  - The first start bit appears on TX 3 cycles after the cycle in which the START_TX edge is sampled.
  - Consecutive frames are separated only by the 2-cycle READ/WAIT gap, during which TX stays high.
- Baud counter:
  - Counts 0 .. CLKS_PER_BIT-1 and wraps.
  - The bit index advances on wrap.
  - The counter restarts at 0 on entry to START.
- Address:
  - MO_rd_add never exceeds NUM_PIXELS-1.
  - No wrap-around occurs; DONE is terminal until the handshake completes.
- Edges on START_TX while in READ through STOP are ignored; a transfer is never restarted mid-image.
- TX is registered and glitch-free.
- TX_BUSY=1 exactly in the states READ through STOP.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with START_TX=1, then release -> TX=1, RD_MO=0, TX_BUSY=0, TX_DONE=0; no transfer starts without a 0->1 edge on START_TX.
2. Single frame, CLKS_PER_BIT=4, NUM_PIXELS=1, memory[0]=0xA5:
   - raise START_TX -> RD_MO pulses one cycle with address 0;
   - TX carries 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles;
   - TX_DONE=1 exactly 42 cycles after the READ cycle.
3. Multi-pixel, NUM_PIXELS=4, memory = 0x00, 0xFF, 0x3C, 0x81 -> the UART monitor decodes those 4 bytes in order; addresses 0..3 are each read exactly once; the inter-frame idle gap is exactly 2 cycles.
4. Ignored restart: toggle START_TX 0->1 again in the middle of frame 2 -> byte sequence and timing are identical to scenario 3.
5. Reset mid-frame: assert rst=0 during DATA bit 3 -> TX=1 the next cycle, MO_rd_add=0. A new START_TX edge resends from pixel 0.
6. Completion handshake: after DONE, keep START_TX=1 for 10 cycles -> TX_DONE stays 1. Drop START_TX -> TX_DONE=0 next cycle. A new edge begins a fresh transfer from address 0.

Source files
------------

// File: rtl/image_uart_tx_if.sv
// Read port of the output image memory, shared between the UART
// readback block (master) and the memory (slave).
interface image_uart_tx_if #(
    parameter int ADDR_W = 19
);
    logic [ADDR_W-1:0] MO_rd_add;
    logic              RD_MO;
    logic [7:0]        MO_rd_data;

    modport master (
        output MO_rd_add,
        output RD_MO,
        input  MO_rd_data
    );

    modport slave (
        input  MO_rd_add,
        input  RD_MO,
        output MO_rd_data
    );
endinterface

// File: rtl/image_uart_tx.sv
// Streams the output image memory, pixel 0 upward, onto an 8N1 UART line
// once the processor signals completion; each byte costs a READ/WAIT fetch.
module image_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int NUM_PIXELS   = 65536,
    parameter int ADDR_W       = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             START_TX,
    image_uart_tx_if.master  mo,
    output logic             TX,
    output logic             TX_BUSY,
    output logic             TX_DONE
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_PIXELS - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        START,
        DATA,
        STOP,
        DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [BAUD_W-1:0]   baud_reg, baud_next;
    logic [2:0]          bit_reg, bit_next;
    logic [7:0]          shift_reg, shift_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic                tx_reg, tx_next;
    logic                start_reg, start_prev_reg;
    logic                start_edge;
    logic                baud_wrap;

    assign start_edge = start_reg & ~start_prev_reg;
    assign baud_wrap  = (baud_reg == BAUD_LAST);

    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        addr_next  = addr_reg;
        case (state_reg)
            IDLE: begin
                if (start_edge) begin
                    addr_next  = '0;
                    state_next = READ;
                end
            end
            READ: state_next = WAIT;
            WAIT: begin
                shift_next = mo.MO_rd_data;
                baud_next  = '0;
                state_next = START;
            end
            START: begin
                if (baud_wrap) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    baud_next = '0;
                    if (addr_reg == ADDR_LAST) begin
                        state_next = DONE;
                    end else begin
                        addr_next  = addr_reg + 1'b1;
                        state_next = READ;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            DONE: begin
                if (!START_TX) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // The line level is derived from the upcoming state so TX is a clean flop.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            baud_reg       <= '0;
            bit_reg        <= '0;
            shift_reg      <= '0;
            addr_reg       <= '0;
            tx_reg         <= 1'b1;
            // Preload both taps so a level already high at release is not an edge.
            start_reg      <= START_TX;
            start_prev_reg <= START_TX;
        end else begin
            state_reg      <= state_next;
            baud_reg       <= baud_next;
            bit_reg        <= bit_next;
            shift_reg      <= shift_next;
            addr_reg       <= addr_next;
            tx_reg         <= tx_next;
            start_reg      <= START_TX;
            start_prev_reg <= start_reg;
        end
    end

    assign TX           = tx_reg;
    assign mo.MO_rd_add = addr_reg;
    assign mo.RD_MO     = (state_reg == READ);
    assign TX_BUSY      = (state_reg == READ) || (state_reg == WAIT) ||
                          (state_reg == START) || (state_reg == DATA) ||
                          (state_reg == STOP);
    assign TX_DONE      = (state_reg == DONE);
endmodule
